// File: rtl/cond_issue_stage.sv
// -----------------------------------------------------------------------------
// cond_issue_stage
//
// Issue stage sitting between instruction decode and execute. It owns the
// architectural CPSR and evaluates each instruction's ARM condition field
// against the NZCV flags. A one-entry output register with valid/ready
// handshakes on both sides passes instructions on to execute. A small
// scoreboard counts issued, executing flag-setters that have not yet written
// back, so that no conditional instruction is evaluated against stale flags.
//
// Parameters
//   MAX_PENDING  : maximum in-flight flag-setting instructions (1..7)
//   CPSR_RESET   : CPSR value loaded on reset
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   flush          in   synchronous pipeline flush
//   in_valid       in   decode presents an instruction
//   in_ready       out  stage accepts this cycle
//   in_inst        in   instruction word, [31:28] = condition code
//   in_sets_flags  in   instruction writes NZCV
//   out_valid      out  output register holds an instruction
//   out_ready      in   execute accepts
//   out_inst       out  registered instruction
//   out_exec       out  condition passed (0 = execute as NOP)
//   out_sets_flags out  registered in_sets_flags & condition pass
//   flag_wr_en     in   writeback updates NZCV
//   flag_wr_nzcv   in   new N,Z,C,V (MSB = N)
//   cpsr           out  architectural CPSR
//   pending        out  scoreboard count of in-flight flag-setters
// -----------------------------------------------------------------------------
module cond_issue_stage #(
  parameter int unsigned MAX_PENDING = 3,
  parameter logic [31:0] CPSR_RESET  = 32'h0000_00D3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic        in_sets_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_exec,
  output logic        out_sets_flags,
  input  logic        flag_wr_en,
  input  logic [3:0]  flag_wr_nzcv,
  output logic [31:0] cpsr,
  output logic [2:0]  pending
);

  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [2:0] MAX_PEND = 3'(MAX_PENDING);

  // ARM condition evaluation; NV (4'hF) never passes.
  function automatic logic cond_pass(input logic [3:0] cond,
                                     input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'h0:    res = z;                    // EQ
      4'h1:    res = !z;                   // NE
      4'h2:    res = c;                    // CS/HS
      4'h3:    res = !c;                   // CC/LO
      4'h4:    res = n;                    // MI
      4'h5:    res = !n;                   // PL
      4'h6:    res = v;                    // VS
      4'h7:    res = !v;                   // VC
      4'h8:    res = c && !z;              // HI
      4'h9:    res = !c || z;              // LS
      4'hA:    res = (n == v);             // GE
      4'hB:    res = (n != v);             // LT
      4'hC:    res = !z && (n == v);       // GT
      4'hD:    res = z || (n != v);        // LE
      4'hE:    res = 1'b1;                 // AL
      default: res = 1'b0;                 // NV
    endcase
    return res;
  endfunction

  logic [31:0] cpsr_q,      cpsr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q,  out_inst_d;
  logic        out_exec_q,  out_exec_d;
  logic        out_sets_q,  out_sets_d;
  logic [2:0]  pending_q,   pending_d;

  logic [3:0]  cond;
  logic [3:0]  eff_nzcv;
  logic        pass;
  logic        stall_cond;
  logic        stall_full;
  logic        stall;
  logic        accept;
  logic        sb_inc;
  logic        sb_dec;

  assign cond = in_inst[31:28];

  // Same-cycle bypass: a writeback in this cycle is already visible to the
  // instruction being evaluated, so a waiting conditional issues with zero
  // extra bubbles after the writeback.
  assign eff_nzcv = flag_wr_en ? flag_wr_nzcv : cpsr_q[31:28];
  assign pass     = cond_pass(cond, eff_nzcv);

  // A conditional instruction must wait while any flag-setter is in flight,
  // unless the last one is writing back right now (bypass covers it).
  assign stall_cond = (cond != COND_AL) && (pending_q != 3'd0) &&
                      !((pending_q == 3'd1) && flag_wr_en);

  // Scoreboard full: a new flag-setter waits unless a writeback frees a slot.
  assign stall_full = in_sets_flags && (pending_q == MAX_PEND) && !flag_wr_en;

  assign stall    = stall_cond || stall_full;
  assign in_ready = (!out_valid_q || out_ready) && !stall && !flush;
  assign accept   = in_valid && in_ready;

  // Only flag-setters whose condition passes will actually write back.
  assign sb_inc = accept && in_sets_flags && pass;
  // Saturate at zero: a spurious writeback never underflows the count.
  assign sb_dec = flag_wr_en && (pending_q != 3'd0);

  always_comb begin
    cpsr_d      = cpsr_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_exec_d  = out_exec_q;
    out_sets_d  = out_sets_q;
    pending_d   = pending_q;

    // The CPSR updates on writeback even during a flush.
    if (flag_wr_en) begin
      cpsr_d[31:28] = flag_wr_nzcv;
    end

    if (flush) begin
      out_valid_d = 1'b0;
      pending_d   = 3'd0;
    end else begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_inst_d  = in_inst;
        out_exec_d  = pass;
        out_sets_d  = in_sets_flags && pass;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end

      case ({sb_inc, sb_dec})
        2'b10:   pending_d = pending_q + 3'd1;
        2'b01:   pending_d = pending_q - 3'd1;
        default: pending_d = pending_q;
      endcase
    end
  end

  // ---- state register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr_q      <= CPSR_RESET;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_exec_q  <= 1'b0;
      out_sets_q  <= 1'b0;
      pending_q   <= 3'd0;
    end else begin
      cpsr_q      <= cpsr_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_exec_q  <= out_exec_d;
      out_sets_q  <= out_sets_d;
      pending_q   <= pending_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_inst       = out_inst_q;
  assign out_exec       = out_exec_q;
  assign out_sets_flags = out_sets_q;
  assign cpsr           = cpsr_q;
  assign pending        = pending_q;

endmodule

// File: tb/tb_cond_issue_stage.sv
module tb_cond_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        in_sets_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_exec;
  logic        out_sets_flags;
  logic        flag_wr_en;
  logic [3:0]  flag_wr_nzcv;
  logic [31:0] cpsr;
  logic [2:0]  pending;

  cond_issue_stage #(.MAX_PENDING(3), .CPSR_RESET(32'h0000_00D3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_sets_flags(in_sets_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_exec(out_exec), .out_sets_flags(out_sets_flags),
    .flag_wr_en(flag_wr_en), .flag_wr_nzcv(flag_wr_nzcv),
    .cpsr(cpsr), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        exec;
    logic        sets;
  } exp_t;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] nzcv;
    logic       exec;
  } vec_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Pop and compare the scoreboard at every output handshake, then advance
  // to just after the next rising edge.
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", out_inst, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("out_inst", out_inst, e.inst);
        chk("out_exec", {31'h0, out_exec}, {31'h0, e.exec});
        chk("out_sets_flags", {31'h0, out_sets_flags}, {31'h0, e.sets});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic sets,
                       input logic exp_ready, input logic exp_exec);
    exp_t e;
    in_valid      = 1'b1;
    in_inst       = inst;
    in_sets_flags = sets;
    #1;
    chk("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
    if (exp_ready) begin
      e.inst = inst;
      e.exec = exp_exec;
      e.sets = sets & exp_exec;
      sb.push_back(e);
    end
    tick();
    in_valid      = 1'b0;
    in_sets_flags = 1'b0;
  endtask

  vec_t vecs[27];

  initial begin
    vecs[0]  = '{4'h0, 4'b0100, 1'b1};
    vecs[1]  = '{4'h0, 4'b0000, 1'b0};
    vecs[2]  = '{4'h1, 4'b0000, 1'b1};
    vecs[3]  = '{4'h1, 4'b0100, 1'b0};
    vecs[4]  = '{4'h2, 4'b0010, 1'b1};
    vecs[5]  = '{4'h3, 4'b0010, 1'b0};
    vecs[6]  = '{4'h4, 4'b1000, 1'b1};
    vecs[7]  = '{4'h5, 4'b1000, 1'b0};
    vecs[8]  = '{4'h6, 4'b0001, 1'b1};
    vecs[9]  = '{4'h7, 4'b0001, 1'b0};
    vecs[10] = '{4'h8, 4'b0010, 1'b1};
    vecs[11] = '{4'h8, 4'b0110, 1'b0};
    vecs[12] = '{4'h9, 4'b0110, 1'b1};
    vecs[13] = '{4'h9, 4'b0010, 1'b0};
    vecs[14] = '{4'hA, 4'b1001, 1'b1};
    vecs[15] = '{4'hA, 4'b1000, 1'b0};
    vecs[16] = '{4'hB, 4'b1000, 1'b1};
    vecs[17] = '{4'hB, 4'b0000, 1'b0};
    vecs[18] = '{4'hC, 4'b0000, 1'b1};
    vecs[19] = '{4'hC, 4'b0100, 1'b0};
    vecs[20] = '{4'hD, 4'b0100, 1'b1};
    vecs[21] = '{4'hD, 4'b1000, 1'b1};
    vecs[22] = '{4'hD, 4'b0000, 1'b0};
    vecs[23] = '{4'hE, 4'b0000, 1'b1};
    vecs[24] = '{4'hE, 4'b1111, 1'b1};
    vecs[25] = '{4'hF, 4'b0000, 1'b0};
    vecs[26] = '{4'h3, 4'b0000, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 32'h0;
    in_sets_flags = 1'b0; out_ready = 1'b1; flag_wr_en = 1'b0; flag_wr_nzcv = 4'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpsr", cpsr, 32'h0000_00D3);
    chk("rst_pending", {29'h0, pending}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_exec", {31'h0, out_exec}, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MOVAL issues with one cycle latency
    issue(32'hE3A0_0001, 1'b0, 1'b1, 1'b1);
    chk("moval_valid", {31'h0, out_valid}, 32'h1);
    chk("moval_exec", {31'h0, out_exec}, 32'h1);
    tick();

    // Condition table, evaluated through the writeback bypass, back-to-back
    for (int i = 0; i < 27; i++) begin
      flag_wr_en   = 1'b1;
      flag_wr_nzcv = vecs[i].nzcv;
      issue({vecs[i].cond, 28'h1A0_0001}, 1'b0, 1'b1, vecs[i].exec);
    end
    flag_wr_en = 1'b0;
    chk("table_cpsr_nzcv", {28'h0, cpsr[31:28]}, 32'h0);
    chk("spurious_wb_pending", {29'h0, pending}, 32'h0);
    tick();

    // Flag hazard: CMP then MOVEQ waits for the writeback
    issue(32'hE350_0000, 1'b1, 1'b1, 1'b1);
    chk("cmp_pending", {29'h0, pending}, 32'h1);
    for (int i = 0; i < 3; i++) issue(32'h03A0_0001, 1'b0, 1'b0, 1'b0);
    chk("hazard_pending_hold", {29'h0, pending}, 32'h1);
    flag_wr_en = 1'b1; flag_wr_nzcv = 4'b0100;
    issue(32'h03A0_0001, 1'b0, 1'b1, 1'b1);
    flag_wr_en = 1'b0;
    chk("hazard_pending_clear", {29'h0, pending}, 32'h0);
    chk("hazard_cpsr", {28'h0, cpsr[31:28]}, 32'h4);
    tick();

    // Scoreboard limit at MAX_PENDING = 3
    issue(32'hE350_0001, 1'b1, 1'b1, 1'b1);
    issue(32'hE350_0002, 1'b1, 1'b1, 1'b1);
    issue(32'hE350_0003, 1'b1, 1'b1, 1'b1);
    chk("sb_full_pending", {29'h0, pending}, 32'h3);
    issue(32'hE350_0004, 1'b1, 1'b0, 1'b0);
    chk("sb_stall_pending", {29'h0, pending}, 32'h3);
    flag_wr_en = 1'b1; flag_wr_nzcv = 4'b0000;
    issue(32'hE350_0004, 1'b1, 1'b1, 1'b1);
    chk("sb_swap_pending", {29'h0, pending}, 32'h3);
    repeat (3) tick();
    flag_wr_en = 1'b0;
    chk("sb_drain_pending", {29'h0, pending}, 32'h0);
    tick();

    // Output backpressure
    out_ready = 1'b0;
    issue(32'hE3A0_0002, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      issue(32'hE3A0_0003, 1'b0, 1'b0, 1'b0);
      chk("bp_out_inst", out_inst, 32'hE3A0_0002);
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    issue(32'hE3A0_0003, 1'b0, 1'b1, 1'b1);
    chk("bp_next_inst", out_inst, 32'hE3A0_0003);
    tick();

    // Flush with pending = 2 and same-cycle writeback
    issue(32'hE350_0005, 1'b1, 1'b1, 1'b1);
    issue(32'hE350_0006, 1'b1, 1'b1, 1'b1);
    chk("pre_flush_pending", {29'h0, pending}, 32'h2);
    flush = 1'b1; flag_wr_en = 1'b1; flag_wr_nzcv = 4'b1001;
    issue(32'hE3A0_0007, 1'b0, 1'b0, 1'b0);
    flush = 1'b0; flag_wr_en = 1'b0;
    chk("flush_pending", {29'h0, pending}, 32'h0);
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_cpsr", {28'h0, cpsr[31:28]}, 32'h9);
    chk("flush_cpsr_low", {8'h0, cpsr[27:4]}, 32'h0000_000D);

    // NV never executes, even as a flag-setter
    issue(32'hF000_0000, 1'b0, 1'b1, 1'b0);
    chk("nv_exec", {31'h0, out_exec}, 32'h0);
    issue(32'hF000_0000, 1'b1, 1'b1, 1'b0);
    chk("nv_sets_pending", {29'h0, pending}, 32'h0);
    tick();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    issue(32'hE350_0008, 1'b1, 1'b1, 1'b1);
    chk("pre_rst_pending", {29'h0, pending}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_pending", {29'h0, pending}, 32'h0);
    chk("async_rst_cpsr", cpsr, 32'h0000_00D3);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    tick();

    chk("sb_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cond_issue_stage.md
# cond_issue_stage

Issue stage between instruction decode and execute. It owns the architectural CPSR and evaluates each instruction's condition field against the flags. It holds a one-entry output register with a valid/ready handshake on both sides. A scoreboard counts flag-setting instructions still in flight, so that no conditional instruction is evaluated against stale flags.

## Interface
- `MAX_PENDING`, default 3: maximum number of issued, executed, flag-setting instructions not yet written back (range 1–7).
- `CPSR_RESET`, default 32'h0000_00D3: CPSR value on reset (SVC mode, I/F set).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_inst` in 32: instruction word; bits [31:28] are the condition code.
- `in_sets_flags` in 1: instruction writes NZCV (S bit or compare).
- `out_valid` out 1: output register holds an instruction.
- `out_ready` in 1: execute accepts.
- `out_inst` out 32: registered instruction.
- `out_exec` out 1: condition passed; 0 means execute treats the instruction as a NOP.
- `out_sets_flags` out 1: `in_sets_flags & out_exec`, registered.
- `flag_wr_en` in 1: writeback updates flags.
- `flag_wr_nzcv` in 4: new N,Z,C,V values, MSB = N.
- `cpsr` out 32: current architectural CPSR.
- `pending` out 3: scoreboard count.

## Operation
- CPSR register:
  - `flag_wr_en` writes `cpsr[31:28] <= flag_wr_nzcv`.
  - Other bits hold their value. This block has no other writers.
- Effective flags for evaluation: `flag_wr_nzcv` when `flag_wr_en` is high, else `cpsr[31:28]`. This is a combinational same-cycle bypass.
- Condition evaluation uses standard ARM semantics:
  - EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE/AL.
  - NV (4'hF) evaluates false.
- Stall condition `stall`, true when either holds:
  - (a) cond ≠ AL, `pending` ≠ 0, and NOT (`pending` == 1 and `flag_wr_en`).
  - (b) `in_sets_flags`, `pending` == `MAX_PENDING`, and `flag_wr_en` is low.
- `in_ready = (!out_valid | out_ready) & !stall & !flush`.
- Accept when `in_valid & in_ready`. On accept, the output register loads `in_inst`, `out_exec` = evaluated condition, `out_sets_flags`, and `out_valid <= 1`.
- If `out_ready` is high with no accept, `out_valid <= 0`. If `out_ready` is low, the output holds stable.
- Scoreboard `pending`:
  - +1 on an accept with `in_sets_flags & cond pass`.
  - −1 on `flag_wr_en`.
  - Both in the same cycle leaves it unchanged.
  - Saturates at 0: a spurious writeback never underflows.
  - Never exceeds `MAX_PENDING`; stall (b) guarantees this.
- Flush:
  - `out_valid <= 0` and `pending <= 0`.
  - No accept occurs in that cycle.
  - A same-cycle `flag_wr_en` still updates the CPSR.

## Timing
- Reset (async assert, synchronous release):
  - `cpsr = CPSR_RESET`, `out_valid = 0`, `out_exec = 0`, `out_sets_flags = 0`, `out_inst = 0`, `pending = 0`.
- Latency is 1 cycle from accept to `out_valid`. Back-to-back throughput is 1 instruction per cycle when not stalled.
- A conditional instruction behind a flag-setter waits until the writeback cycle. It is accepted in that same cycle via the bypass, giving 0 extra bubbles beyond writeback.
- `in_ready` depends combinationally on `out_ready`, `flag_wr_en`, `flush` and `in_inst`. It must not depend on `in_valid`.
- Reset asserted mid-operation discards the held instruction and the scoreboard immediately.

## Test plan
- Reset check:
  - Stimulus: assert reset, then release it.
  - Response: `cpsr` = 0x0000_00D3, `pending` = 0, `out_valid` = 0.
  - Stimulus: issue `MOVAL` (0xE3A0_0001).
  - Response: `out_valid` next cycle, `out_exec` = 1.
- Flag hazard:
  - Stimulus: issue `CMP` (0xE350_0000, sets_flags). Follow it with `MOVEQ` (0x03A0_0001).
  - Response: `in_ready` stays 0 until `flag_wr_en` with nzcv = 4'b0100. The MOVEQ is accepted in that cycle with `out_exec` = 1, and `pending` returns to 0.
- Scoreboard limit:
  - Stimulus: with `MAX_PENDING` = 3, issue 4 AL flag-setters and hold writeback.
  - Response: the 4th stalls with `pending` = 3. A single writeback lets it accept, and `pending` stays 3.
- Output backpressure:
  - Stimulus: hold `out_ready` = 0 for 5 cycles.
  - Response: `out_inst` is stable and `in_ready` = 0. On release, the next instruction issues the cycle after.
- Flush and NV:
  - Stimulus: flush with `pending` = 2 and a same-cycle writeback of 4'b1001.
  - Response: `pending` = 0, `out_valid` = 0, `cpsr[31:28]` = 4'b1001.
  - Stimulus: an NV-condition instruction (0xF000_0000).
  - Response: `out_exec` = 0.
